// File: rtl/rr_arbiter.sv
// Round-robin arbiter with registered one-hot grant and grant hold.
// Optional hold-time limit compiled in with RR_ARBITER_HOLD_LIMIT_EN.

module rr_arbiter_port #(
  parameter int K    = 0,
  parameter int ID_W = 2
) (
  input  logic            req,
  input  logic            gnt,
  input  logic            expire,
  input  logic [ID_W-1:0] last,
  output logic            elig,
  output logic            elig_hi
);
  localparam logic [ID_W:0] IDX = (ID_W+1)'(K);

  // A holder whose time ran out must not win its own re-arbitration.
  assign elig    = req & ~(expire & gnt);
  assign elig_hi = elig & (IDX > {1'b0, last});
endmodule

module rr_arbiter #(
  parameter int NUM_PORTS = 4,
  parameter int MAX_HOLD  = 8,
  parameter int ID_W      = $clog2(NUM_PORTS)
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic [NUM_PORTS-1:0] req_i,
  output logic [NUM_PORTS-1:0] gnt_o,
  output logic [ID_W-1:0]      gnt_id_o,
  output logic                 gnt_valid_o
);
  typedef enum logic {IDLE, OWNED} state_t;

  state_t                state_q, state_d;
  logic [NUM_PORTS-1:0]  gnt_d;
  logic [ID_W-1:0]       id_d;
  logic [ID_W-1:0]       last_q, last_d;
  logic [NUM_PORTS-1:0]  elig, elig_hi;
  logic                  expire, keep;
  logic                  hit_lo, hit_hi;
  logic [ID_W-1:0]       pick_lo, pick_hi, pick_id;

  if (NUM_PORTS < 2 || MAX_HOLD < 2) begin : g_param_chk
    $error("rr_arbiter: NUM_PORTS and MAX_HOLD must be >= 2");
  end

`ifdef RR_ARBITER_HOLD_LIMIT_EN
  localparam int HW = $clog2(MAX_HOLD);
  logic [HW-1:0] hold_q;
  logic          at_limit;

  assign at_limit = (hold_q == HW'(MAX_HOLD-1));
  assign expire   = (state_q == OWNED) && at_limit && |(req_i & ~gnt_o);

  // Sole requester at the limit keeps ownership and starts a fresh period.
  always_ff @(posedge clk_i) begin
    if (reset_i)       hold_q <= '0;
    else if (!keep)    hold_q <= '0;
    else if (at_limit) hold_q <= '0;
    else               hold_q <= hold_q + 1'b1;
  end
`else
  assign expire = 1'b0;
`endif

  for (genvar k = 0; k < NUM_PORTS; k++) begin : g_port
    rr_arbiter_port #(.K(k), .ID_W(ID_W)) u_port (
      .req     (req_i[k]),
      .gnt     (gnt_o[k]),
      .expire  (expire),
      .last    (last_q),
      .elig    (elig[k]),
      .elig_hi (elig_hi[k])
    );
  end

  // Lowest eligible index above last_q wins; otherwise wrap to lowest overall.
  always_comb begin
    hit_lo  = 1'b0;
    hit_hi  = 1'b0;
    pick_lo = '0;
    pick_hi = '0;
    for (int k = NUM_PORTS-1; k >= 0; k--) begin
      if (elig[k]) begin
        hit_lo  = 1'b1;
        pick_lo = ID_W'(k);
      end
      if (elig_hi[k]) begin
        hit_hi  = 1'b1;
        pick_hi = ID_W'(k);
      end
    end
    pick_id = hit_hi ? pick_hi : pick_lo;
  end

  assign keep = (state_q == OWNED) && |(req_i & gnt_o) && !expire;

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_o;
    id_d    = gnt_id_o;
    last_d  = last_q;
    if (!keep) begin
      if (hit_lo) begin
        state_d = OWNED;
        gnt_d   = NUM_PORTS'(1) << pick_id;
        id_d    = pick_id;
        last_d  = pick_id;
      end else begin
        state_d = IDLE;
        gnt_d   = '0;
        id_d    = '0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      gnt_o       <= '0;
      gnt_id_o    <= '0;
      gnt_valid_o <= 1'b0;
      last_q      <= ID_W'(NUM_PORTS-1);
    end else begin
      state_q     <= state_d;
      gnt_o       <= gnt_d;
      gnt_id_o    <= id_d;
      gnt_valid_o <= (state_d == OWNED);
      last_q      <= last_d;
    end
  end
endmodule

// File: tb/tb_rr_arbiter.sv
// Directed and randomised checks of rr_arbiter with NUM_PORTS=4, MAX_HOLD=4.
module tb_rr_arbiter;
  localparam int NP = 4;
  localparam int MH = 4;
  localparam int IW = 2;
`ifdef RR_ARBITER_HOLD_LIMIT_EN
  localparam bit HL = 1'b1;
`else
  localparam bit HL = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset_i;
  logic [NP-1:0] req_i;
  logic [NP-1:0] gnt_o;
  logic [IW-1:0] gnt_id_o;
  logic          gnt_valid_o;

  int n_vec = 0;
  int n_err = 0;

  rr_arbiter #(.NUM_PORTS(NP), .MAX_HOLD(MH)) dut (
    .clk_i       (clk),
    .reset_i     (reset_i),
    .req_i       (req_i),
    .gnt_o       (gnt_o),
    .gnt_id_o    (gnt_id_o),
    .gnt_valid_o (gnt_valid_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [NP-1:0] g, input logic [IW-1:0] id,
                         input logic v);
    chk({tag, "_gnt"}, 32'(gnt_o), 32'(g));
    chk({tag, "_id"}, 32'(gnt_id_o), 32'(id));
    chk({tag, "_vld"}, 32'(gnt_valid_o), 32'(v));
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [NP-1:0] r;
    logic [NP-1:0] eg;
    logic [IW-1:0] eid;
    int wait_c[NP];
    int held[NP];
    int lim[NP];

    reset_i = 1'b1;
    req_i   = '0;
    cyc();
    cyc();
    chk_out("reset", 4'b0000, 2'd0, 1'b0);
    reset_i = 1'b0;

    // rotation as each holder releases
    req_i = 4'b1111; cyc(); chk_out("rot0", 4'b0001, 2'd0, 1'b1);
    req_i = 4'b1110; cyc(); chk_out("rot1", 4'b0010, 2'd1, 1'b1);
    req_i = 4'b1100; cyc(); chk_out("rot2", 4'b0100, 2'd2, 1'b1);
    req_i = 4'b1000; cyc(); chk_out("rot3", 4'b1000, 2'd3, 1'b1);
    req_i = 4'b0000; cyc(); chk_out("rot_idle", 4'b0000, 2'd0, 1'b0);

    // two persistent requesters: limited build alternates every MH cycles
    req_i = 4'b1001;
    for (int i = 0; i < 12; i++) begin
      cyc();
      eg  = (HL && ((i / MH) % 2 == 1)) ? 4'b1000 : 4'b0001;
      eid = (HL && ((i / MH) % 2 == 1)) ? 2'd3 : 2'd0;
      chk_out("hold2", eg, eid, 1'b1);
    end
    req_i = 4'b0000; cyc(); chk_out("hold2_rel", 4'b0000, 2'd0, 1'b0);

    // sole requester never loses its grant at expiry
    req_i = 4'b0100;
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk_out("solo", 4'b0100, 2'd2, 1'b1);
    end

    // reset mid-grant
    reset_i = 1'b1;
    req_i   = 4'b1111;
    cyc(); chk_out("rst_mid", 4'b0000, 2'd0, 1'b0);
    reset_i = 1'b0;
    cyc(); chk_out("rst_first", 4'b0001, 2'd0, 1'b1);
    req_i = 4'b0000; cyc(); chk_out("rst_rel", 4'b0000, 2'd0, 1'b0);

    // randomised traffic; holders release within MH cycles so the wait bound applies
    r = '0;
    for (int k = 0; k < NP; k++) begin
      wait_c[k] = 0;
      held[k]   = 0;
      lim[k]    = $urandom_range(1, MH);
    end
    for (int c = 0; c < 500; c++) begin
      cyc();
      chk("rnd_onehot", 32'($onehot0(gnt_o)), 32'd1);
      chk("rnd_subset", 32'(gnt_o & ~r), 32'd0);
      eid = '0;
      for (int k = 0; k < NP; k++) if (gnt_o[k]) eid = IW'(k);
      chk("rnd_id", 32'(gnt_id_o), 32'(eid));
      chk("rnd_vld", 32'(gnt_valid_o), 32'(|gnt_o));
      for (int k = 0; k < NP; k++) begin
        if (gnt_o[k]) begin
          wait_c[k] = 0;
          held[k]++;
        end else begin
          held[k] = 0;
          wait_c[k] = r[k] ? wait_c[k] + 1 : 0;
        end
        chk("rnd_wait", 32'(wait_c[k] <= 3*MH+1), 32'd1);
      end
      for (int k = 0; k < NP; k++) begin
        if (gnt_o[k]) begin
          if (held[k] >= lim[k]) begin
            r[k]   = 1'b0;
            lim[k] = $urandom_range(1, MH);
          end
        end else if (!r[k] && $urandom_range(0, 3) == 0) begin
          r[k] = 1'b1;
        end
      end
      req_i = r;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
